// File: rtl/bsg_manycore_wh_edge_arbiter.sv
// Wormhole edge arbiter: merges num_in_p wormhole links onto one off-array
// channel. Round-robin grant on each header; the granted link stays locked
// until its last body flit has passed. Pure mux datapath, no flit storage.
module bsg_manycore_wh_edge_arbiter #(
    parameter int unsigned num_in_p        = 4,
    parameter int unsigned wh_flit_width_p = 16,
    parameter int unsigned wh_cord_width_p = 4,
    parameter int unsigned wh_len_width_p  = 3
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic [num_in_p-1:0]                 v_i,
    input  logic [num_in_p*wh_flit_width_p-1:0] data_i,
    output logic [num_in_p-1:0]                 ready_and_o,
    output logic                                v_o,
    output logic [wh_flit_width_p-1:0]          data_o,
    input  logic                                ready_and_i
);

    localparam int unsigned sel_width_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;

    typedef enum logic {StIdle, StBusy} state_e;

    state_e                    state_r;
    logic [sel_width_lp-1:0]   last_r;
    logic [sel_width_lp-1:0]   lock_r;
    logic [wh_len_width_p-1:0] cnt_r;

    logic [sel_width_lp-1:0]    rr_sel;
    logic                       rr_found;
    int                         rr_dist;
    int                         rr_best;
    logic [sel_width_lp-1:0]    sel;
    logic                       lock_v;
    logic [wh_flit_width_p-1:0] lock_data;
    logic [wh_len_width_p-1:0]  hdr_len;
    logic                       grant;
    logic                       xfer;

    // Round-robin pick: smallest distance above last_r among valid inputs
    always_comb begin
        rr_sel   = last_r;
        rr_found = 1'b0;
        rr_dist  = 0;
        rr_best  = int'(num_in_p);
        for (int i = 0; i < int'(num_in_p); i++) begin
            if (v_i[i]) begin
                rr_dist = (i + int'(num_in_p) - 1 - int'(last_r)) % int'(num_in_p);
                if (rr_dist < rr_best) begin
                    rr_best  = rr_dist;
                    rr_sel   = sel_width_lp'(i);
                    rr_found = 1'b1;
                end
            end
        end
    end

    // Output mux and handshake; locked link owns the channel while busy
    always_comb begin
        sel       = (state_r == StBusy) ? lock_r : rr_sel;
        data_o    = '0;
        lock_v    = 1'b0;
        lock_data = '0;
        for (int i = 0; i < int'(num_in_p); i++) begin
            if (sel == sel_width_lp'(i)) begin
                data_o = data_i[i*wh_flit_width_p +: wh_flit_width_p];
            end
            if (lock_r == sel_width_lp'(i)) begin
                lock_v    = v_i[i];
                lock_data = data_i[i*wh_flit_width_p +: wh_flit_width_p];
            end
        end
        v_o         = !reset_i && ((state_r == StBusy) ? lock_v : rr_found);
        grant       = !reset_i && ready_and_i && ((state_r == StBusy) || rr_found);
        ready_and_o = '0;
        for (int i = 0; i < int'(num_in_p); i++) begin
            ready_and_o[i] = grant && (sel == sel_width_lp'(i));
        end
        hdr_len = data_o[wh_cord_width_p +: wh_len_width_p];
        xfer    = v_o && ready_and_i;
    end

    // Packet FSM: header locks the link, body count releases it
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= StIdle;
            cnt_r   <= '0;
            lock_r  <= '0;
            last_r  <= sel_width_lp'(num_in_p - 1);
        end else if (xfer) begin
            unique case (state_r)
                StIdle: begin
                    last_r <= sel;
                    if (hdr_len != '0) begin
                        lock_r  <= sel;
                        cnt_r   <= hdr_len;
                        state_r <= StBusy;
                    end
                end
                StBusy: begin
                    cnt_r <= cnt_r - 1'b1;
                    if (cnt_r == wh_len_width_p'(1)) begin
                        state_r <= StIdle;
                    end
                end
                default: state_r <= StIdle;
            endcase
        end
    end

`ifndef SYNTHESIS
    logic                       hold_r;
    logic [wh_flit_width_p-1:0] hold_data_r;

    // Upstream contract: a stalled locked flit must keep its data
    always_ff @(posedge clk_i) begin
        hold_r      <= !reset_i && (state_r == StBusy) && lock_v && !ready_and_i;
        hold_data_r <= lock_data;
        if (!reset_i) begin
            assert (num_in_p >= 2) else $error("num_in_p must be at least 2");
            if (hold_r && (state_r == StBusy) && lock_v) begin
                assert (lock_data == hold_data_r)
                    else $error("locked input changed data while stalled");
            end
        end
    end
`endif

endmodule

// File: tb/tb_bsg_manycore_wh_edge_arbiter.sv
// Bench for the wormhole edge arbiter: per-input packet queues feed the DUT,
// a packet-level reference model predicts grants and the output stream.
module tb_bsg_manycore_wh_edge_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int CW = 4;
    localparam int LW = 3;

    typedef logic [W-1:0] flit_t;

    logic           clk = 1'b0;
    logic           reset_i;
    logic [N-1:0]   v_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   ready_and_o;
    logic           v_o;
    logic [W-1:0]   data_o;
    logic           ready_and_i;

    bsg_manycore_wh_edge_arbiter #(
        .num_in_p       (N),
        .wh_flit_width_p(W),
        .wh_cord_width_p(CW),
        .wh_len_width_p (LW)
    ) dut (
        .clk_i      (clk),
        .reset_i    (reset_i),
        .v_i        (v_i),
        .data_i     (data_i),
        .ready_and_o(ready_and_o),
        .v_o        (v_o),
        .data_o     (data_o),
        .ready_and_i(ready_and_i)
    );

    always #5 clk = ~clk;

    flit_t q[N][$];
    int total = 0;
    int bad = 0;
    int owner = -1;     // input currently holding the channel, -1 when free
    int rem = 0;        // body flits still owed by the owner
    int last = N - 1;   // most recent header winner
    int dut_out = 0;    // output transfers seen on the DUT pins
    int start;
    int guard;

    task automatic push_pkt(input int i, input int len);
        flit_t h;
        h = flit_t'($urandom);
        h[CW-1:0] = CW'(i);
        h[CW+LW-1:CW] = LW'(len);
        q[i].push_back(h);
        for (int b = 0; b < len; b++) q[i].push_back(flit_t'($urandom));
    endtask

    task automatic flush();
        for (int i = 0; i < N; i++) q[i].delete();
    endtask

    // One clock: drive at negedge, check 1 time unit later, advance model
    task automatic step(input bit rst, input int vpct, input bit rdy);
        logic [N-1:0] vin;
        logic [N-1:0] exp_rdy;
        logic         exp_v;
        flit_t        head;
        int           sel;
        bit           found;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            vin[i] = (q[i].size() > 0) && ($urandom_range(99) < vpct);
            data_i[i*W +: W] = (q[i].size() > 0) ? q[i][0] : flit_t'($urandom);
        end
        v_i = vin;
        reset_i = rst;
        ready_and_i = rdy;
        #1;
        found = 1'b0;
        sel = 0;
        if (owner >= 0) begin
            sel = owner;
            found = 1'b1;
            exp_v = vin[owner];
        end else begin
            for (int k = 1; k <= N; k++) begin
                if (!found && vin[(last + k) % N]) begin
                    found = 1'b1;
                    sel = (last + k) % N;
                end
            end
            exp_v = found;
        end
        if (rst) exp_v = 1'b0;
        exp_rdy = (!rst && found && rdy) ? (N'(1) << sel) : '0;
        total++;
        assert (v_o === exp_v)
            else begin bad++; $error("FAIL v_o got=%b exp=%b", v_o, exp_v); end
        if (rst || found) begin
            total++;
            assert (ready_and_o === exp_rdy)
                else begin bad++; $error("FAIL ready got=%b exp=%b", ready_and_o, exp_rdy); end
        end
        if (exp_v) begin
            head = q[sel][0];
            total++;
            assert (data_o === head)
                else begin bad++; $error("FAIL data got=%h exp=%h", data_o, head); end
        end
        if (v_o === 1'b1 && rdy) dut_out++;
        if (rst) begin
            owner = -1;
            rem = 0;
            last = N - 1;
        end else if (exp_v && rdy) begin
            head = q[sel][0];
            if (owner < 0) begin
                last = sel;
                if (head[CW+LW-1:CW] != '0) begin
                    owner = sel;
                    rem = int'(head[CW+LW-1:CW]);
                end
            end else begin
                rem--;
                if (rem == 0) owner = -1;
            end
            void'(q[sel].pop_front());
        end
    endtask

    initial begin
        reset_i = 1'b1;
        v_i = '0;
        data_i = '0;
        ready_and_i = 1'b1;

        // Reset with traffic pending: outputs stay quiet
        push_pkt(0, 2);
        push_pkt(2, 1);
        step(1, 100, 1);
        step(1, 100, 1);
        flush();

        // Single header, len 0
        push_pkt(0, 0);
        step(0, 100, 1);
        total++;
        assert (ready_and_o === 4'b0001)
            else begin bad++; $error("FAIL t1_ready got=%b exp=%b", ready_and_o, 4'b0001); end

        // in1 len 3 holds the channel while in2 waits
        start = dut_out;
        push_pkt(1, 3);
        push_pkt(2, 0);
        repeat (5) step(0, 100, 1);
        total++;
        assert (dut_out - start === 5)
            else begin bad++; $error("FAIL t2_flits got=%0d exp=%0d", dut_out - start, 5); end

        // All inputs busy with len 1 packets: full utilisation
        start = dut_out;
        for (int p = 0; p < 3; p++) for (int i = 0; i < N; i++) push_pkt(i, 1);
        repeat (24) step(0, 100, 1);
        total++;
        assert (dut_out - start === 24)
            else begin bad++; $error("FAIL t3_util got=%0d exp=%0d", dut_out - start, 24); end

        // Backpressure and source bubbles mid-packet
        start = dut_out;
        push_pkt(3, 2);
        push_pkt(0, 0);
        step(0, 100, 1);
        repeat (5) step(0, 50, 0);
        guard = 0;
        while (q[3].size() > 0 && guard < 60) begin
            step(0, 60, 1);
            guard++;
        end
        total++;
        assert (guard < 60)
            else begin bad++; $error("FAIL t4_timeout got=%0d exp=<60", guard); end
        step(0, 100, 1);
        total++;
        assert (dut_out - start === 4)
            else begin bad++; $error("FAIL t4_flits got=%0d exp=%0d", dut_out - start, 4); end

        // Maximum length packet
        start = dut_out;
        push_pkt(2, 7);
        repeat (8) step(0, 100, 1);
        total++;
        assert (dut_out - start === 8)
            else begin bad++; $error("FAIL t5_flits got=%0d exp=%0d", dut_out - start, 8); end
        push_pkt(0, 0);
        push_pkt(1, 0);
        repeat (2) step(0, 100, 1);

        // Reset mid-packet, then input 0 wins
        push_pkt(1, 3);
        repeat (2) step(0, 100, 1);
        step(1, 100, 1);
        flush();
        push_pkt(1, 0);
        push_pkt(0, 0);
        step(0, 100, 1);
        total++;
        assert (data_o[CW-1:0] === 4'd0)
            else begin bad++; $error("FAIL t6_winner got=%0d exp=%0d", data_o[CW-1:0], 0); end
        step(0, 100, 1);

        // Random traffic
        repeat (600) begin
            if ($urandom_range(99) < 40) begin
                int i;
                i = int'($urandom_range(N - 1));
                if (q[i].size() < 20) push_pkt(i, int'($urandom_range(7)));
            end
            step(0, int'($urandom_range(100, 30)), $urandom_range(99) < 75);
        end
        guard = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) > 0 && guard < 2000) begin
            step(0, 100, 1);
            guard++;
        end
        total++;
        assert (guard < 2000)
            else begin bad++; $error("FAIL drain_timeout got=%0d exp=<2000", guard); end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
